// File: rtl/mem_hier_ctrl.sv
// Purpose : miss controller shared by I-cache and D-cache in front of one unified line-wide memory.
// Latency : hits 0 cycles; clean miss = 2 + memory latency; dirty D miss adds one writeback transaction.
// Backpress: one miss in flight at a time; the losing/other port waits (hits on the idle port still served).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req/i_addr/i_hit         fetch request, word address, I-cache tag match
//   i_rdy/i_sel/i_we           fetch word valid, word select, I-cache line fill strobe
//   d_re/d_we/d_addr           load / store request and word address
//   d_hit/d_dirty              D-cache tag match, resident line dirty
//   d_victim_la/d_victim_line  resident D line address and data (writeback source)
//   d_rdy/d_we_line            load/store accepted, D-cache line fill strobe
//   fill_data                  registered memory read data, shared by both fills
//   m_addr/m_re/m_we/m_wr_data memory line command (registered)
//   m_rd_data/m_rdy            memory read data, one-cycle completion pulse
//
// Optional feature: define MEM_HIER_RR_ARB_EN for round-robin arbitration between
// simultaneous I and D misses; otherwise a D miss always wins.

module mem_hier_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int WORD_W     = 16,
    parameter int LINE_WORDS = 4,
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int LINE_W    = WORD_W * LINE_WORDS,
    localparam int LA_W      = ADDR_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction side
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_hit,
    output logic              i_rdy,
    output logic [OFF_W-1:0]  i_sel,
    output logic              i_we,
    // data side
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_hit,
    input  logic              d_dirty,
    input  logic [LA_W-1:0]   d_victim_la,
    input  logic [LINE_W-1:0] d_victim_line,
    output logic              d_rdy,
    output logic              d_we_line,
    // shared fill bus
    output logic [LINE_W-1:0] fill_data,
    // memory port
    output logic [LA_W-1:0]   m_addr,
    output logic              m_re,
    output logic              m_we,
    output logic [LINE_W-1:0] m_wr_data,
    input  logic [LINE_W-1:0] m_rd_data,
    input  logic              m_rdy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WB     = 3'd1,
        S_RD_D   = 3'd2,
        S_FILL_D = 3'd3,
        S_RD_I   = 3'd4,
        S_FILL_I = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;

    logic               r_m_re;
    logic               r_m_we;
    logic [LA_W-1:0]    r_m_addr;
    logic [LINE_W-1:0]  r_m_wr_data;
    logic [LINE_W-1:0]  r_fill_data;
    // D miss line address, kept across the writeback so the refill reads the right line
    logic [LA_W-1:0]    r_d_la;

    logic               w_m_re_nx;
    logic               w_m_we_nx;
    logic [LA_W-1:0]    w_m_addr_nx;
    logic [LINE_W-1:0]  w_m_wr_data_nx;
    logic [LA_W-1:0]    w_d_la_nx;
    logic               w_fill_ld;

    logic               w_i_miss;
    logic               w_d_miss;
    logic               w_grant_d;
    logic               w_grant_i;
    logic               w_d_busy;

    // word offset of the data address is only meaningful to the cache array
    logic               w_unused_d_off;
    assign w_unused_d_off = ^d_addr[OFF_W-1:0];

    // ------------------------------------------------------------------
    // Hit path: combinational, served in any state unless that port is
    // itself mid-miss (hit-under-miss on the other port).
    // ------------------------------------------------------------------
    assign w_d_busy = (r_state == S_WB) || (r_state == S_RD_D) || (r_state == S_FILL_D);
    assign i_rdy    = i_req & i_hit & (r_state != S_FILL_I);
    assign d_rdy    = (d_re | d_we) & d_hit & ~w_d_busy;
    assign i_sel    = i_addr[OFF_W-1:0];

    assign i_we      = (r_state == S_FILL_I);
    assign d_we_line = (r_state == S_FILL_D);

    assign fill_data = r_fill_data;
    assign m_addr    = r_m_addr;
    assign m_re      = r_m_re;
    assign m_we      = r_m_we;
    assign m_wr_data = r_m_wr_data;

    // ------------------------------------------------------------------
    // Arbitration between simultaneous misses
    // ------------------------------------------------------------------
    assign w_i_miss = i_req & ~i_hit;
    assign w_d_miss = (d_re | d_we) & ~d_hit;

`ifdef MEM_HIER_RR_ARB_EN
    // 1 = D was granted last; reset value says I went last so D wins the first tie
    logic r_last_d;

    assign w_grant_d = w_d_miss & (~w_i_miss | ~r_last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if ((r_state == S_IDLE) && (w_grant_d || w_grant_i)) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = w_d_miss;
`endif

    assign w_grant_i = w_i_miss & ~w_grant_d;

    // ------------------------------------------------------------------
    // FSM next state and next memory command
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx     = r_state;
        w_m_re_nx      = r_m_re;
        w_m_we_nx      = r_m_we;
        w_m_addr_nx    = r_m_addr;
        w_m_wr_data_nx = r_m_wr_data;
        w_d_la_nx      = r_d_la;
        w_fill_ld      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_d_la_nx = d_addr[ADDR_W-1:OFF_W];
                    if (d_dirty) begin
                        // victim must reach memory before the refill overwrites it
                        w_state_nx     = S_WB;
                        w_m_we_nx      = 1'b1;
                        w_m_addr_nx    = d_victim_la;
                        w_m_wr_data_nx = d_victim_line;
                    end else begin
                        w_state_nx  = S_RD_D;
                        w_m_re_nx   = 1'b1;
                        w_m_addr_nx = d_addr[ADDR_W-1:OFF_W];
                    end
                end else if (w_grant_i) begin
                    w_state_nx  = S_RD_I;
                    w_m_re_nx   = 1'b1;
                    w_m_addr_nx = i_addr[ADDR_W-1:OFF_W];
                end
            end
            S_WB: begin
                if (m_rdy) begin
                    // write drops and read rises on the same edge: never both high
                    w_state_nx  = S_RD_D;
                    w_m_we_nx   = 1'b0;
                    w_m_re_nx   = 1'b1;
                    w_m_addr_nx = r_d_la;
                end
            end
            S_RD_D: begin
                if (m_rdy) begin
                    w_state_nx = S_FILL_D;
                    w_m_re_nx  = 1'b0;
                    w_fill_ld  = 1'b1;
                end
            end
            S_RD_I: begin
                if (m_rdy) begin
                    w_state_nx = S_FILL_I;
                    w_m_re_nx  = 1'b0;
                    w_fill_ld  = 1'b1;
                end
            end
            S_FILL_D: w_state_nx = S_IDLE;
            S_FILL_I: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_m_re      <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wr_data <= '0;
            r_fill_data <= '0;
            r_d_la      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_m_re      <= w_m_re_nx;
            r_m_we      <= w_m_we_nx;
            r_m_addr    <= w_m_addr_nx;
            r_m_wr_data <= w_m_wr_data_nx;
            r_d_la      <= w_d_la_nx;
            if (w_fill_ld) begin
                r_fill_data <= m_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_hier_ctrl.sv
// Purpose : self-checking bench for mem_hier_ctrl (default parameters).
// Latency : memory model answers after a programmable number of command cycles.
// Backpress: memory completion is a single m_rdy pulse; bench reacts to fill strobes.

module tb_mem_hier_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_hit;
    logic        i_rdy;
    logic [1:0]  i_sel;
    logic        i_we;
    logic        d_re;
    logic        d_we;
    logic [15:0] d_addr;
    logic        d_hit;
    logic        d_dirty;
    logic [13:0] d_victim_la;
    logic [63:0] d_victim_line;
    logic        d_rdy;
    logic        d_we_line;
    logic [63:0] fill_data;
    logic [13:0] m_addr;
    logic        m_re;
    logic        m_we;
    logic [63:0] m_wr_data;
    logic [63:0] m_rd_data;
    logic        m_rdy;

    mem_hier_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_hit         (i_hit),
        .i_rdy         (i_rdy),
        .i_sel         (i_sel),
        .i_we          (i_we),
        .d_re          (d_re),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_hit         (d_hit),
        .d_dirty       (d_dirty),
        .d_victim_la   (d_victim_la),
        .d_victim_line (d_victim_line),
        .d_rdy         (d_rdy),
        .d_we_line     (d_we_line),
        .fill_data     (fill_data),
        .m_addr        (m_addr),
        .m_re          (m_re),
        .m_we          (m_we),
        .m_wr_data     (m_wr_data),
        .m_rd_data     (m_rd_data),
        .m_rdy         (m_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [13:0] la;
        logic [63:0] data;
    } cmd_t;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
    } fill_t;

    cmd_t  exp_cmd[$];
    fill_t exp_fill[$];

    int n_total = 0;
    int n_bad   = 0;
    int mem_lat = 3;
    int both_n  = 0;
    // per-wait observation counters, written only by the main thread
    int re_n, we_n, i_rdy_n, d_rdy_n;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [13:0] la);
        return {4{2'b10, la}};
    endfunction

    task automatic push_cmd(input bit we, input logic [13:0] la, input logic [63:0] data);
        cmd_t c;
        c.we = we; c.la = la; c.data = data;
        exp_cmd.push_back(c);
    endtask

    task automatic push_fill(input bit is_d, input logic [13:0] la);
        fill_t f;
        f.is_d = is_d; f.data = line_of(la);
        exp_fill.push_back(f);
    endtask

    // Wait (bounded) for the next fill strobe; cyc = negedges until it is seen.
    task automatic wait_strobe(input string tag, output int cyc, output bit is_d);
        cyc = 0; is_d = 1'b0;
        re_n = 0; we_n = 0; i_rdy_n = 0; d_rdy_n = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (m_re)  re_n++;
            if (m_we)  we_n++;
            if (i_rdy) i_rdy_n++;
            if (d_rdy) d_rdy_n++;
        end while (!(i_we || d_we_line) && cyc < 60);
        if (!(i_we || d_we_line)) chk(tag, 64'd0, 64'd1);
        is_d = d_we_line;
    endtask

    // Memory model: completes a command after mem_lat cycles and checks it against the scoreboard.
    initial begin : mem_model
        int cnt;
        cmd_t e;
        cnt = 0;
        m_rdy = 1'b0;
        m_rd_data = '0;
        forever begin
            @(negedge clk);
            if (m_re && m_we) both_n++;
            if (!rst_n) begin
                m_rdy = 1'b0;
                cnt = 0;
            end else begin
                if (m_rdy) begin
                    m_rdy = 1'b0;
                    cnt = 0;
                end
                if (m_re || m_we) begin
                    cnt++;
                    if (cnt >= mem_lat) begin
                        m_rdy = 1'b1;
                        m_rd_data = line_of(m_addr);
                        if (exp_cmd.size() == 0) begin
                            chk("cmd_unexpected", 64'd1, 64'd0);
                        end else begin
                            e = exp_cmd.pop_front();
                            chk("cmd_we", 64'(m_we), 64'(e.we));
                            chk("cmd_addr", 64'(m_addr), 64'(e.la));
                            if (e.we) chk("cmd_wdata", m_wr_data, e.data);
                        end
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Fill monitor: every fill strobe must match the next expected fill.
    initial begin : fill_mon
        fill_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (i_we || d_we_line)) begin
                if (exp_fill.size() == 0) begin
                    chk("fill_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_fill.pop_front();
                    chk("fill_port", 64'(d_we_line), 64'(e.is_d));
                    chk("fill_data", fill_data, e.data);
                end
            end
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        int cyc;
        bit is_d;
        int dn;
        int k;
        logic [15:0] d_seq [3];

        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; i_hit = 1'b0;
        d_re = 1'b0; d_we = 1'b0; d_addr = '0; d_hit = 1'b0; d_dirty = 1'b0;
        d_victim_la = '0; d_victim_line = '0;
        repeat (3) @(negedge clk);
        chk("rst_m_re", 64'(m_re), 64'd0);
        chk("rst_m_we", 64'(m_we), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_wr_data", m_wr_data, 64'd0);
        chk("rst_fill_data", fill_data, 64'd0);
        chk("rst_strobes", 64'({i_we, d_we_line}), 64'd0);
        chk("rst_rdys", 64'({i_rdy, d_rdy}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // I hit: same-cycle ready, word select, no memory traffic
        i_req = 1'b1; i_addr = 16'h0012; i_hit = 1'b1;
        #1;
        chk("hit_i_rdy", 64'(i_rdy), 64'd1);
        chk("hit_i_sel", 64'(i_sel), 64'd2);
        @(negedge clk);
        chk("hit_no_cmd", 64'({m_re, m_we}), 64'd0);

        // clean I miss, memory latency 3
        push_cmd(1'b0, 14'h010, 64'd0);
        push_fill(1'b0, 14'h010);
        i_addr = 16'h0040; i_hit = 1'b0;
        wait_strobe("imiss_timeout", cyc, is_d);
        chk("imiss_lat", 64'(cyc), 64'd4);
        chk("imiss_re_cycles", 64'(re_n), 64'd3);
        chk("imiss_is_i", 64'(is_d), 64'd0);
        i_hit = 1'b1;
        #1;
        chk("imiss_rdy_in_fill", 64'(i_rdy), 64'd0);
        @(negedge clk);
        chk("imiss_rdy_after", 64'(i_rdy), 64'd1);
        chk("imiss_we_once", 64'(i_we), 64'd0);

        // dirty store miss: writeback of victim then refill
        i_req = 1'b0;
        push_cmd(1'b1, 14'h021, 64'hDEAD_BEEF_0123_4567);
        push_cmd(1'b0, 14'h041, 64'd0);
        push_fill(1'b1, 14'h041);
        d_we = 1'b1; d_addr = 16'h0104; d_hit = 1'b0; d_dirty = 1'b1;
        d_victim_la = 14'h021; d_victim_line = 64'hDEAD_BEEF_0123_4567;
        wait_strobe("dmiss_timeout", cyc, is_d);
        chk("dmiss_lat", 64'(cyc), 64'd7);
        chk("dmiss_we_cycles", 64'(we_n), 64'd3);
        chk("dmiss_re_cycles", 64'(re_n), 64'd3);
        chk("dmiss_no_rdy", 64'(d_rdy_n), 64'd0);
        chk("dmiss_is_d", 64'(is_d), 64'd1);
        d_hit = 1'b1; d_dirty = 1'b0;
        @(negedge clk);
        chk("dmiss_store_done", 64'(d_rdy), 64'd1);
        d_we = 1'b0;

        // I hit under an outstanding clean D load miss
        push_cmd(1'b0, 14'h080, 64'd0);
        push_fill(1'b1, 14'h080);
        d_re = 1'b1; d_addr = 16'h0200; d_hit = 1'b0;
        i_req = 1'b1; i_addr = 16'h0041; i_hit = 1'b1;
        wait_strobe("hum_timeout", cyc, is_d);
        chk("hum_lat", 64'(cyc), 64'd4);
        chk("hum_i_rdy_cycles", 64'(i_rdy_n), 64'd4);
        chk("hum_i_sel", 64'(i_sel), 64'd1);
        d_hit = 1'b1;
        @(negedge clk);
        chk("hum_d_rdy", 64'(d_rdy), 64'd1);

        // simultaneous I and D misses, three D misses back to back, latency 1
        mem_lat = 1;
        d_seq[0] = 16'h0400; d_seq[1] = 16'h0500; d_seq[2] = 16'h0600;
`ifdef MEM_HIER_RR_ARB_EN
        push_cmd(1'b0, 14'h100, 64'd0); push_fill(1'b1, 14'h100);
        push_cmd(1'b0, 14'h0C0, 64'd0); push_fill(1'b0, 14'h0C0);
        push_cmd(1'b0, 14'h140, 64'd0); push_fill(1'b1, 14'h140);
        push_cmd(1'b0, 14'h180, 64'd0); push_fill(1'b1, 14'h180);
`else
        push_cmd(1'b0, 14'h100, 64'd0); push_fill(1'b1, 14'h100);
        push_cmd(1'b0, 14'h140, 64'd0); push_fill(1'b1, 14'h140);
        push_cmd(1'b0, 14'h180, 64'd0); push_fill(1'b1, 14'h180);
        push_cmd(1'b0, 14'h0C0, 64'd0); push_fill(1'b0, 14'h0C0);
`endif
        i_req = 1'b1; i_addr = 16'h0300; i_hit = 1'b0;
        d_re = 1'b1; d_addr = d_seq[0]; d_hit = 1'b0;
        dn = 0;
        for (k = 0; k < 4; k++) begin
            wait_strobe("tie_timeout", cyc, is_d);
            if (k == 0) chk("tie_first_lat", 64'(cyc), 64'd2);
            if (is_d) begin
                dn++;
                if (dn < 3) d_addr = d_seq[dn];
                else        d_hit = 1'b1;
            end else begin
                i_hit = 1'b1;
            end
        end
        @(negedge clk);
        chk("tie_both_rdy", 64'({i_rdy, d_rdy}), 64'd3);
        i_req = 1'b0; d_re = 1'b0;

        // asynchronous reset in the middle of an I refill
        mem_lat = 5;
        i_req = 1'b1; i_addr = 16'h0800; i_hit = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_re && k < 10);
        chk("rst_mid_re_up", 64'(m_re), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_re_async", 64'(m_re), 64'd0);
        chk("rst_mid_no_fill", 64'(i_we), 64'd0);
        i_hit = 1'b1; i_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_hold", 64'({m_re, i_we}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_idle", 64'({m_re, m_we, i_we}), 64'd0);

        // fresh miss after reset proves the controller is back in IDLE
        mem_lat = 2;
        push_cmd(1'b0, 14'h011, 64'd0);
        push_fill(1'b0, 14'h011);
        i_req = 1'b1; i_addr = 16'h0044; i_hit = 1'b0;
        wait_strobe("post_rst_timeout", cyc, is_d);
        chk("post_rst_lat", 64'(cyc), 64'd3);
        i_hit = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 64'(i_rdy), 64'd1);
        i_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
        chk("fill_queue_empty", 64'(exp_fill.size()), 64'd0);
        chk("re_we_exclusive", 64'(both_n), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_hier_ctrl.md
# mem_hier_ctrl

Parametrised miss controller shared by the instruction and data caches in front of the single unified memory. It services I-fetch and D-load/store requests against external cache arrays, arbitrates misses onto one line-wide memory port, writes back dirty data victims before refill, and allows hits on the idle port to proceed while the other port's miss is outstanding. It replaces the fixed 16-bit, 4-word, instruction-only miss path.

## Interface
Parameters:
- ADDR_W, 16, word-address width
- WORD_W, 16, data word width
- LINE_WORDS, 4, words per line; power of two, ≥2; OFF_W = log2(LINE_WORDS), LINE_W = WORD_W*LINE_WORDS, LA_W = ADDR_W-OFF_W

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch word address
- i_hit  in  1  I-cache tag match for i_addr
- i_rdy  out  1  fetch word valid this cycle
- i_sel  out  OFF_W  word select within line, = i_addr[OFF_W-1:0]
- i_we  out  1  one-cycle I-cache line fill strobe
- d_re, d_we  in  1  load / store request (mutually exclusive)
- d_addr  in  ADDR_W  data word address
- d_hit, d_dirty  in  1  D-cache tag match / resident line dirty
- d_victim_la  in  LA_W  line address of resident D line
- d_victim_line  in  LINE_W  resident D line data
- d_rdy  out  1  load data / store accepted this cycle
- d_we_line  out  1  one-cycle D-cache line fill strobe (fill installs clean)
- fill_data  out  LINE_W  registered memory read data, shared fill bus
- m_addr  out  LA_W  memory line address
- m_re, m_we  out  1  memory read / write command
- m_wr_data  out  LINE_W  writeback data
- m_rd_data  in  LINE_W  memory read data
- m_rdy  in  1  one-cycle completion pulse from memory

## Operation
- States: IDLE, WB, RD_D, FILL_D, RD_I, FILL_I.
- i_rdy = i_req & i_hit & (state≠FILL_I); d_rdy = (d_re|d_we) & d_hit & (state∉{WB,RD_D,FILL_D}). Both combinational; hits on the non-missing port are served in any state (hit-under-miss).
- IDLE: evaluate misses (i_miss = i_req&~i_hit, d_miss = (d_re|d_we)&~d_hit). Grant per arbitration (Configuration). Latch miss line address.
- D grant: if d_dirty → WB with m_we=1, m_addr=d_victim_la, m_wr_data=d_victim_line (latched); on m_rdy → RD_D. Else → RD_D directly.
- RD_D: m_re=1, m_addr=latched d_addr[ADDR_W-1:OFF_W]; on m_rdy capture m_rd_data into fill_data → FILL_D.
- FILL_D: d_we_line=1 one cycle → IDLE. Store misses are write-allocate; the store completes as a hit afterwards.
- RD_I/FILL_I: same as RD_D/FILL_D using i_addr and i_we.
- m_addr, m_re, m_we, m_wr_data registered; held stable until the m_rdy cycle, deasserted the cycle after. m_re and m_we never both high.
- Request withdrawn or address changed mid-miss: transaction completes with latched address and the fill still occurs.
- m_rdy outside WB/RD_*: ignored.

## Timing
- Reset (async): state=IDLE; m_re=m_we=0; m_addr=0; m_wr_data=0; fill_data=0; i_we=d_we_line=0. i_rdy/d_rdy follow their equations (0 with no request). Reset mid-transaction aborts immediately, no fill strobe.
- Hit latency: 0 cycles (same-cycle rdy).
- Clean miss: grant in cycle T; m_re high from T+1; m_rdy at T+k; fill strobe at T+k+1; IDLE at T+k+2; rdy at T+k+2 if the request is held.
- Dirty D miss: adds one WB transaction; m_re rises the cycle after WB's m_rdy.

## Configuration
- MEM_HIER_RR_ARB_EN defined: round-robin between simultaneous I and D misses; a 1-bit last-grant flag (reset → I granted last, so D wins the first tie) toggles per grant.
- Undefined: fixed priority, D miss always wins over I miss.

## Test plan
- LINE_WORDS=4, i_addr=0x0012 hit → i_rdy=1 same cycle, i_sel=2'b10, no memory command.
- I miss at 0x0040, memory latency 3 → m_re with m_addr=0x010 for 3 cycles, i_we pulses once, i_rdy returns when i_hit rises.
- Dirty store miss d_addr=0x0104, d_victim_la=0x021 → m_we with m_addr=0x021 and victim data, then m_re with m_addr=0x041, d_we_line pulse, d_rdy on the hit.
- Simultaneous I/D clean misses, three back-to-back → fixed: D,D,D served first; with MEM_HIER_RR_ARB_EN: D,I,D alternation.
- I hit during outstanding D miss → i_rdy=1 each requested cycle while in RD_D.
- rst_n low mid-RD_I → m_re=0 asynchronously, no i_we, IDLE after release.
